// File: rtl/team_06_fsm_pkg.sv
// team_06_fsm shared types and defaults
// voice-path control FSM package
package team_06_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TALK   = 2'd1,
    LISTEN = 2'd2,
    MUTED  = 2'd3
  } state_t;

  localparam logic [7:0] NG_THRESHOLD_DEF = 8'd64;
  localparam int         NUM_EFFECTS_DEF  = 5;

endpackage

// File: rtl/team_06_edge_detect.sv
// team_06_edge_detect
// 1-bit rising-edge detector, one previous-sample register
module team_06_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;

  // remember last sampled level of the button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= din;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/team_06_fsm.sv
// team_06_fsm
// talk/listen/mute control FSM with noise gate and effect select
module team_06_fsm
  import team_06_fsm_pkg::*;
#(
  parameter logic [7:0] NG_THRESHOLD = NG_THRESHOLD_DEF,
  parameter int         NUM_EFFECTS  = NUM_EFFECTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mic_aud,
  input  logic [7:0] spk_aud,
  input  logic       ng_en,
  input  logic       ptt_en,
  input  logic       effect,
  input  logic       mute,
  output logic [1:0] state,
  output logic       eff_en,
  output logic       vol_en,
  output logic [2:0] current_effect,
  output logic       mute_tog,
  output logic       noise_gate_tog
);

  localparam logic [2:0] EFF_LAST = 3'(NUM_EFFECTS - 1);

  state_t state_q;
  state_t state_d;
  logic   ng_rise;
  logic   eff_rise;
  logic   mute_rise;
  logic   mic_valid;

  team_06_edge_detect u_ng_ed (
    .clk  (clk),
    .rst  (rst),
    .din  (ng_en),
    .rise (ng_rise)
  );

  team_06_edge_detect u_eff_ed (
    .clk  (clk),
    .rst  (rst),
    .din  (effect),
    .rise (eff_rise)
  );

  team_06_edge_detect u_mute_ed (
    .clk  (clk),
    .rst  (rst),
    .din  (mute),
    .rise (mute_rise)
  );

  // toggle flags on their button edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mute_tog       <= 1'b0;
      noise_gate_tog <= 1'b0;
    end else begin
      if (mute_rise) mute_tog <= ~mute_tog;
      if (ng_rise)   noise_gate_tog <= ~noise_gate_tog;
    end
  end

  // effect slot advances in any state, wraps to slot 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_effect <= 3'd0;
    end else if (eff_rise) begin
      if (current_effect == EFF_LAST)
        current_effect <= 3'd0;
      else
        current_effect <= current_effect + 3'd1;
    end
  end

  assign mic_valid = ~noise_gate_tog
                   | (mic_aud >= NG_THRESHOLD);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next state: mute, then talk, then listen
  always_comb begin
    state_d = IDLE;
    if (mute_tog)
      state_d = MUTED;
    else if (ptt_en && mic_valid)
      state_d = TALK;
    else if (spk_aud != 8'd0)
      state_d = LISTEN;
  end

  // Moore outputs decoded from registered state
  always_comb begin
    eff_en = 1'b0;
    vol_en = 1'b0;
    unique case (state_q)
      TALK:   eff_en = (current_effect != 3'd0);
      LISTEN: vol_en = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_team_06_fsm.sv
// tb_team_06_fsm
// directed vectors for team_06_fsm
module tb_team_06_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mic_aud;
  logic [7:0] spk_aud;
  logic       ng_en;
  logic       ptt_en;
  logic       effect;
  logic       mute;
  logic [1:0] state;
  logic       eff_en;
  logic       vol_en;
  logic [2:0] current_effect;
  logic       mute_tog;
  logic       noise_gate_tog;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TALK = 2'd1;
  localparam logic [1:0] S_LIST = 2'd2;
  localparam logic [1:0] S_MUTE = 2'd3;

  team_06_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .mic_aud        (mic_aud),
    .spk_aud        (spk_aud),
    .ng_en          (ng_en),
    .ptt_en         (ptt_en),
    .effect         (effect),
    .mute           (mute),
    .state          (state),
    .eff_en         (eff_en),
    .vol_en         (vol_en),
    .current_effect (current_effect),
    .mute_tog       (mute_tog),
    .noise_gate_tog (noise_gate_tog)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string      tag,
    input logic [1:0] st,
    input logic       ee,
    input logic       ve,
    input logic [2:0] ce,
    input logic       mt,
    input logic       ng
  );
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".eff_en"}, 32'(eff_en), 32'(ee));
    check({tag, ".vol_en"}, 32'(vol_en), 32'(ve));
    check({tag, ".eff"}, 32'(current_effect), 32'(ce));
    check({tag, ".mute"}, 32'(mute_tog), 32'(mt));
    check({tag, ".ng"}, 32'(noise_gate_tog), 32'(ng));
  endtask

  task automatic pulse_eff();
    effect = 1'b1;
    tick();
    effect = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    mic_aud = 8'd0;
    spk_aud = 8'd0;
    ng_en = 1'b0;
    ptt_en = 1'b0;
    effect = 1'b0;
    mute = 1'b0;
    #23;
    chk_all("rst", S_IDLE, 0, 0, 3'd0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk_all("idle", S_IDLE, 0, 0, 3'd0, 0, 0);

    // talk with effect, gate off
    ptt_en = 1'b1;
    mic_aud = 8'd60;
    effect = 1'b1;
    tick();
    chk_all("talk1", S_TALK, 1, 0, 3'd1, 0, 0);
    effect = 1'b0;
    ptt_en = 1'b0;
    tick();

    // gate on: threshold boundary
    ng_en = 1'b1;
    tick();
    check("ng_on", 32'(noise_gate_tog), 32'd1);
    ng_en = 1'b0;
    ptt_en = 1'b1;
    mic_aud = 8'd60;
    tick();
    check("gate60", 32'(state), 32'(S_IDLE));
    mic_aud = 8'd64;
    tick();
    check("gate64", 32'(state), 32'(S_TALK));
    mic_aud = 8'd65;
    tick();
    check("gate65", 32'(state), 32'(S_TALK));

    // listen
    ptt_en = 1'b0;
    spk_aud = 8'd57;
    tick();
    chk_all("listen", S_LIST, 0, 1, 3'd1, 0, 1);
    spk_aud = 8'd0;
    tick();
    check("spk0", 32'(state), 32'(S_IDLE));
    spk_aud = 8'd57;
    tick();

    // mute in listen: two-clock latency
    mute = 1'b1;
    tick();
    check("mt_flag", 32'(mute_tog), 32'd1);
    check("mt_lat", 32'(state), 32'(S_LIST));
    mute = 1'b0;
    tick();
    chk_all("muted", S_MUTE, 0, 0, 3'd1, 1, 1);
    mute = 1'b1;
    tick();
    check("unmt", 32'(mute_tog), 32'd0);
    mute = 1'b0;
    tick();
    check("unmt_st", 32'(state), 32'(S_LIST));

    // talk wins over listen if mic valid
    ptt_en = 1'b1;
    mic_aud = 8'd100;
    tick();
    check("duplex_t", 32'(state), 32'(S_TALK));
    mic_aud = 8'd10;
    tick();
    check("duplex_l", 32'(state), 32'(S_LIST));

    // simultaneous edges
    mute = 1'b1;
    effect = 1'b1;
    ng_en = 1'b1;
    tick();
    check("sim_mt", 32'(mute_tog), 32'd1);
    check("sim_ng", 32'(noise_gate_tog), 32'd0);
    check("sim_ef", 32'(current_effect), 32'd2);
    effect = 1'b0;
    ng_en = 1'b0;
    // held mute: no more toggles
    tick();
    tick();
    chk_all("held", S_MUTE, 0, 0, 3'd2, 1, 0);
    mute = 1'b0;
    pulse_eff();
    check("eff_mut", 32'(current_effect), 32'd3);
    check("st_mut", 32'(state), 32'(S_MUTE));

    // reset mid-run, mute held through release
    rst = 1'b0;
    mute = 1'b1;
    #2;
    chk_all("arst", S_IDLE, 0, 0, 3'd0, 0, 0);
    ptt_en = 1'b0;
    spk_aud = 8'd0;
    tick();
    rst = 1'b1;
    tick();
    check("hold_rel", 32'(mute_tog), 32'd1);
    tick();
    check("hold_rel2", 32'(mute_tog), 32'd1);
    check("hold_st", 32'(state), 32'(S_MUTE));

    // effect wrap from fresh reset
    rst = 1'b0;
    mute = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      pulse_eff();
      check($sformatf("wrap%0d", i),
            32'(current_effect), 32'(i % 5));
    end
    pulse_eff();
    pulse_eff();
    check("pre_rst", 32'(current_effect), 32'd2);
    rst = 1'b0;
    #2;
    chk_all("rst_mid", S_IDLE, 0, 0, 3'd0, 0, 0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
